farm_car_detector: RTL and testbench

Conditions the raw farm-road inductive-loop signal into the clean vehicle-request input `c` consumed directly downstream by the traffic-light controller. It synchronizes and debounces the loop, tracks the number of queued farm-road vehicles, and keeps `c` asserted until the queue is served. The controller's farm-green output is fed back as `fg` to retire served vehicles.

---
 rtl/farm_car_detector.sv | 154 +++++++++++++++
 tb/tb_farm_car_detector.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/farm_car_detector.sv
// Farm-road loop conditioner: synchronizes and debounces the inductive loop, counts
// queued vehicles and holds the request c until the queue is served or gapped out.
module farm_car_detector #(
    parameter int DEB_CYC = 4,
    parameter int GAP     = 8,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             loop_raw,
    input  logic             fg,
    output logic             c,
    output logic [CNT_W-1:0] car_cnt,
    output logic             arrive,
    output logic             depart,
    output logic             sat
);

    typedef enum logic [1:0] {
        ABSENT   = 2'd0,
        RISE_CHK = 2'd1,
        PRESENT  = 2'd2,
        FALL_CHK = 2'd3
    } state_t;

    localparam logic [3:0]       DEB_LAST = 4'(DEB_CYC - 1);
    localparam logic [7:0]       GAP_LAST = 8'(GAP - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic       sync1;
    logic       s;
    state_t     state;
    state_t     state_nxt;
    logic [3:0] deb_cnt;
    logic [3:0] deb_nxt;
    logic       arrive_nxt;
    logic       depart_nxt;
    logic [7:0] gap_tmr;
    logic       gap_cond;
    logic       gap_out;

    // Two-flop synchronizer; only s is used past this point.
    // NOTE: sequential state always uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= loop_raw;
            s     <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ABSENT;
            deb_cnt <= 4'd0;
            arrive  <= 1'b0;
            depart  <= 1'b0;
        end else begin
            state   <= state_nxt;
            deb_cnt <= deb_nxt;
            arrive  <= arrive_nxt;
            depart  <= depart_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no branch leaves a variable unassigned (no latches).
        state_nxt  = state;
        deb_nxt    = deb_cnt;
        arrive_nxt = 1'b0;
        depart_nxt = 1'b0;
        case (state)
            ABSENT: begin
                if (s) begin
                    state_nxt = RISE_CHK;
                    deb_nxt   = 4'd1;
                end
            end
            RISE_CHK: begin
                if (!s) begin
                    state_nxt = ABSENT;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt  = PRESENT;
                    arrive_nxt = 1'b1;
                end else begin
                    deb_nxt = deb_cnt + 4'd1;
                end
            end
            PRESENT: begin
                if (!s) begin
                    state_nxt = FALL_CHK;
                    deb_nxt   = 4'd1;
                end
            end
            FALL_CHK: begin
                if (s) begin
                    state_nxt = PRESENT;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt  = ABSENT;
                    depart_nxt = 1'b1;
                end else begin
                    deb_nxt = deb_cnt + 4'd1;
                end
            end
            default: state_nxt = ABSENT;
        endcase
    end

    // Gap-out only runs while the loop is settled empty and farm green serves a queue.
    assign gap_cond = (state == ABSENT) && fg && (car_cnt != '0);
    assign gap_out  = gap_cond && (gap_tmr == GAP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_tmr <= 8'd0;
        end else if (gap_cond && !gap_out) begin
            gap_tmr <= gap_tmr + 8'd1;
        end else begin
            gap_tmr <= 8'd0;
        end
    end

    // arrive, depart and gap-out are mutually exclusive by construction of the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            car_cnt <= '0;
            sat     <= 1'b0;
        end else if (gap_out) begin
            car_cnt <= '0;
            sat     <= 1'b0;
        end else if (arrive_nxt) begin
            if (car_cnt == CNT_MAX) begin
                sat <= 1'b1;
            end else begin
                car_cnt <= car_cnt + CNT_ONE;
            end
        end else if (depart_nxt && fg) begin
            if (car_cnt != '0) begin
                car_cnt <= car_cnt - CNT_ONE;
            end
            if (car_cnt <= CNT_ONE) begin
                sat <= 1'b0;
            end
        end
    end

    always_comb begin
        c = (state == PRESENT) || (state == FALL_CHK) || (car_cnt != '0);
    end

endmodule

// File: tb/tb_farm_car_detector.sv
// Self-checking bench for farm_car_detector: directed scenarios plus randomized loop/fg
// traffic compared against a run-length behavioural model of the loop and queue.
module tb_farm_car_detector;

    localparam int DEB_CYC = 4;
    localparam int GAP     = 8;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int VW      = CNT_W + 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             loop_raw;
    logic             fg;
    logic             c;
    logic [CNT_W-1:0] car_cnt;
    logic             arrive;
    logic             depart;
    logic             sat;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: accepted loop level plus length of the current opposite-level run.
    bit m_hist[$];
    bit m_level;
    int m_run;
    int m_cnt;
    int m_gap;
    bit m_sat;
    bit m_arrive;
    bit m_depart;

    farm_car_detector #(
        .DEB_CYC(DEB_CYC),
        .GAP    (GAP),
        .CNT_W  (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .loop_raw(loop_raw),
        .fg      (fg),
        .c       (c),
        .car_cnt (car_cnt),
        .arrive  (arrive),
        .depart  (depart),
        .sat     (sat)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_hist   = '{1'b0, 1'b0};
        m_level  = 1'b0;
        m_run    = 0;
        m_cnt    = 0;
        m_gap    = 0;
        m_sat    = 1'b0;
        m_arrive = 1'b0;
        m_depart = 1'b0;
    endfunction

    function automatic void model_step(input bit lr, input bit f);
        bit s_now;
        bit settled_empty;
        bit serving;
        s_now = m_hist.pop_front();
        m_hist.push_back(lr);
        settled_empty = (m_level == 1'b0) && (m_run == 0);
        serving       = settled_empty && f && (m_cnt != 0);
        m_arrive = 1'b0;
        m_depart = 1'b0;
        if (s_now != m_level) begin
            m_run++;
            if (m_run == DEB_CYC) begin
                m_level = s_now;
                m_run   = 0;
                if (s_now) m_arrive = 1'b1;
                else       m_depart = 1'b1;
            end
        end else begin
            m_run = 0;
        end
        if (serving && m_gap == GAP - 1) begin
            m_cnt = 0;
            m_gap = 0;
            m_sat = 1'b0;
        end else if (serving) begin
            m_gap++;
        end else begin
            m_gap = 0;
        end
        if (m_arrive) begin
            if (m_cnt == CNT_MAX) m_sat = 1'b1;
            else                  m_cnt++;
        end else if (m_depart && f) begin
            if (m_cnt <= 1) m_sat = 1'b0;
            if (m_cnt > 0)  m_cnt--;
        end
    endfunction

    function automatic logic [VW-1:0] pack(input bit cc, input int cnt, input bit a,
                                           input bit d, input bit s);
        return {cc, CNT_W'(cnt), a, d, s};
    endfunction

    function automatic logic [VW-1:0] observed();
        return {c, car_cnt, arrive, depart, sat};
    endfunction

    // Drive inputs at the falling edge, clock once, return at the next falling edge.
    task automatic step(input logic lr, input logic f);
        loop_raw = lr;
        fg       = f;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(lr, f);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [VW-1:0] exp_v;
        rst      = 1'b1;
        loop_raw = 1'b1;
        fg       = 1'b1;
        repeat (3) @(negedge clk);
        exp_v = pack(0, 0, 0, 0, 0);
        n_total++;
        if (observed() !== exp_v)
            $display("FAIL reset_state: got c/cnt/arr/dep/sat=%b want %b", observed(), exp_v);
        else n_pass++;
        loop_raw = 1'b0;
        fg       = 1'b0;
        rst      = 1'b0;
        model_reset();
    endtask

    task automatic test_glitch();
        logic [VW-1:0] exp_v;
        for (int e = 0; e < 12; e++) begin
            step(e < 3, 1'b0);
            exp_v = pack(0, 0, 0, 0, 0);
            n_total++;
            if (observed() !== exp_v)
                $display("FAIL glitch edge %0d: got %b want %b", e, observed(), exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_arrival_no_fg();
        logic [VW-1:0] exp_v;
        for (int e = 0; e < 8; e++) begin
            step(1'b1, 1'b0);
            exp_v = pack(e >= 5, (e >= 5) ? 1 : 0, e == 5, 0, 0);
            n_total++;
            if (observed() !== exp_v)
                $display("FAIL arrival edge %0d: got %b want %b", e, observed(), exp_v);
            else n_pass++;
        end
        for (int e = 0; e < 8; e++) begin
            step(1'b0, 1'b0);
            exp_v = pack(1, 1, 0, e == 5, 0);
            n_total++;
            if (observed() !== exp_v)
                $display("FAIL depart_no_fg edge %0d: got %b want %b", e, observed(), exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_service();
        logic [VW-1:0] exp_v;
        for (int e = 0; e < 8; e++) begin
            step(1'b1, 1'b1);
            exp_v = pack(1, (e >= 5) ? 2 : 1, e == 5, 0, 0);
            n_total++;
            if (observed() !== exp_v)
                $display("FAIL service_arrive edge %0d: got %b want %b", e, observed(), exp_v);
            else n_pass++;
        end
        for (int e = 0; e < 15; e++) begin
            step(1'b0, 1'b1);
            exp_v = pack(e < 13, (e < 5) ? 2 : ((e < 13) ? 1 : 0), 0, e == 5, 0);
            n_total++;
            if (observed() !== exp_v)
                $display("FAIL service_gap edge %0d: got %b want %b", e, observed(), exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_no_gap_without_fg();
        logic [VW-1:0] exp_v;
        repeat (8) step(1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0);
        for (int e = 0; e < 20; e++) begin
            step(1'b0, 1'b0);
            exp_v = pack(1, 1, 0, 0, 0);
            n_total++;
            if (observed() !== exp_v)
                $display("FAIL hold_no_fg edge %0d: got %b want %b", e, observed(), exp_v);
            else n_pass++;
        end
        for (int e = 0; e < 10; e++) begin
            step(1'b0, 1'b1);
            exp_v = pack(e < 7, (e < 7) ? 1 : 0, 0, 0, 0);
            n_total++;
            if (observed() !== exp_v)
                $display("FAIL late_gap edge %0d: got %b want %b", e, observed(), exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        logic [VW-1:0] exp_v;
        for (int k = 1; k <= 9; k++) begin
            repeat (8) step(1'b1, 1'b0);
            exp_v = pack(1, (k < CNT_MAX) ? k : CNT_MAX, 0, 0, k >= 8);
            n_total++;
            if (observed() !== exp_v)
                $display("FAIL sat_arrival %0d: got %b want %b", k, observed(), exp_v);
            else n_pass++;
            repeat (8) step(1'b0, 1'b0);
        end
        for (int e = 0; e < 10; e++) begin
            step(1'b0, 1'b1);
            exp_v = pack(e < 7, (e < 7) ? CNT_MAX : 0, 0, 0, e < 7);
            n_total++;
            if (observed() !== exp_v)
                $display("FAIL sat_gap edge %0d: got %b want %b", e, observed(), exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_debounce();
        logic [VW-1:0] exp_v;
        repeat (8) step(1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0);
        exp_v = pack(1, 1, 0, 0, 0);
        n_total++;
        if (observed() !== exp_v)
            $display("FAIL pre_reset: got %b want %b", observed(), exp_v);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        exp_v = pack(0, 0, 0, 0, 0);
        n_total++;
        if (observed() !== exp_v)
            $display("FAIL async_reset: got %b want %b", observed(), exp_v);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int e = 0; e < 8; e++) begin
            step(1'b1, 1'b0);
            exp_v = pack(e >= 5, (e >= 5) ? 1 : 0, e == 5, 0, 0);
            n_total++;
            if (observed() !== exp_v)
                $display("FAIL recount edge %0d: got %b want %b", e, observed(), exp_v);
            else n_pass++;
        end
        repeat (8) step(1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [VW-1:0] exp_v;
        logic          lr;
        logic          f;
        int            run_left;
        lr       = 1'b0;
        f        = 1'b0;
        run_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                lr       = ~lr;
                run_left = $urandom_range(1, 11);
            end
            run_left--;
            if ($urandom_range(0, 11) == 0) f = ~f;
            step(lr, f);
            exp_v = pack(m_level || (m_cnt != 0), m_cnt, m_arrive, m_depart, m_sat);
            n_total++;
            if (observed() !== exp_v)
                $display("FAIL random cycle %0d: got %b want %b", i, observed(), exp_v);
            else n_pass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        loop_raw = 1'b0;
        fg       = 1'b0;
        model_reset();
        test_reset();
        test_glitch();
        test_arrival_no_fg();
        test_service();
        test_no_gap_without_fg();
        test_saturation();
        test_reset_mid_debounce();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
